button_debounce: RTL and testbench

- Input-side counterpart of the LED blink driver: a user pushbutton pin comes into the fabric, is cleaned up, and is presented as a stable level plus single-cycle events.
- Stages: 2-FF synchroniser, polarity normalisation, stability-counter debounce FSM, optional long-press detector.
- Runs in the PLL clock domain (24 MHz). Reset comes from PLL not-locked.
- Feeds mode/control logic that currently has no user input.

---
 rtl/button_debounce_pkg.sv | 14 +
 rtl/button_debounce_sync2.sv | 23 ++
 rtl/button_debounce.sv | 114 +++++++++++
 tb/tb_button_debounce.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/button_debounce_pkg.sv
// rtl/button_debounce_pkg.sv - shared FSM encoding and 24 MHz timing defaults for the button debouncer
package button_debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int DEBOUNCE_10MS = 240000;
  localparam int HOLD_1S       = 24000000;

endpackage

// File: rtl/button_debounce_sync2.sv
// rtl/button_debounce_sync2.sv - generic two-flop synchroniser for asynchronous pins
module button_debounce_sync2 #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - pushbutton synchroniser, debounce FSM and press/release/long-press pulses
// Long-press detection is built only when BUTTON_DEBOUNCE_LONG_PRESS_EN is defined.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_10MS,
  parameter int LONG_PRESS_CYCLES = HOLD_1S,
  parameter int ACTIVE_LOW        = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse
);

  localparam int            DW         = $clog2(DEBOUNCE_CYCLES);
  localparam logic          IDLE_LEVEL = (ACTIVE_LOW != 0);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_cfg_check
    $error("button_debounce: invalid DEBOUNCE_CYCLES / LONG_PRESS_CYCLES");
  end

  btn_state_t    state, state_next;
  logic [DW-1:0] deb_cnt, deb_cnt_next;
  logic          sync_q, s, commit;
  logic          press_next, release_next;

  // Reset to the idle pin level so leaving reset never looks like a press.
  button_debounce_sync2 #(.RESET_VALUE(IDLE_LEVEL)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (sync_q)
  );

  assign s         = sync_q ^ IDLE_LEVEL;
  assign btn_level = (state == PRESSED) || (state == RELEASE_WAIT);
  assign commit    = (s != btn_level) && (deb_cnt == DEB_LAST);

  always_comb begin
    state_next   = state;
    deb_cnt_next = '0;
    press_next   = 1'b0;
    release_next = 1'b0;
    if (s != btn_level && !commit) deb_cnt_next = deb_cnt + 1'b1;
    case (state)
      RELEASED:     if (s) state_next = PRESS_WAIT;
      PRESS_WAIT: begin
        if (!s) begin
          state_next = RELEASED;
        end else if (commit) begin
          state_next = PRESSED;
          press_next = 1'b1;
        end
      end
      PRESSED:      if (!s) state_next = RELEASE_WAIT;
      RELEASE_WAIT: begin
        if (s) begin
          state_next = PRESSED;
        end else if (commit) begin
          state_next   = RELEASED;
          release_next = 1'b1;
        end
      end
      default:      state_next = RELEASED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= RELEASED;
      deb_cnt       <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_next;
      deb_cnt       <= deb_cnt_next;
      press_pulse   <= press_next;
      release_pulse <= release_next;
    end
  end

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam int            HW        = $clog2(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

  logic [HW-1:0] hold_cnt;
  logic          long_next;

  // A release committing on the same edge wins, keeping the pulses disjoint.
  assign long_next = btn_level && !release_next && (hold_cnt == HOLD_LAST - 1'b1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt         <= '0;
      long_press_pulse <= 1'b0;
    end else begin
      long_press_pulse <= long_next;
      if (press_next) begin
        hold_cnt <= '0;
      end else if (btn_level && hold_cnt != HOLD_LAST) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end
`else
  assign long_press_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - self-checking bench for button_debounce (active-high and active-low pins)
module tb_button_debounce;

  localparam int N = 4;
  localparam int L = 20;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam int EXP_LONGS = 1;
`else
  localparam int EXP_LONGS = 0;
`endif

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic btn_in = 1'b0;
  logic lvl, prs, rel, lng;
  logic lvl_n, prs_n, rel_n, lng_n;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int n_press, n_release, n_long, last_press, last_long;

  always #5 clk = ~clk;

  button_debounce #(.DEBOUNCE_CYCLES(N), .LONG_PRESS_CYCLES(L), .ACTIVE_LOW(0)) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .btn_level(lvl), .press_pulse(prs), .release_pulse(rel), .long_press_pulse(lng)
  );

  button_debounce #(.DEBOUNCE_CYCLES(N), .LONG_PRESS_CYCLES(L), .ACTIVE_LOW(1)) dut_n (
    .clk(clk), .reset(reset), .btn_in(~btn_in),
    .btn_level(lvl_n), .press_pulse(prs_n), .release_pulse(rel_n), .long_press_pulse(lng_n)
  );

  // Reference: level flips once the last N synchronised samples (pin delayed 2 edges) all differ.
  bit   hist[$];
  int   t, press_t;
  logic m_level = 1'b0, m_press = 1'b0, m_release = 1'b0, m_long = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hist = {};
      for (int i = 0; i < N + 2; i++) hist.push_back(1'b0);
      t = 0; press_t = -100000;
      m_level = 1'b0; m_press = 1'b0; m_release = 1'b0; m_long = 1'b0;
    end else begin
      bit all_diff;
      t++;
      hist.push_back(btn_in);
      void'(hist.pop_front());
      all_diff = 1'b1;
      for (int i = 0; i < N; i++) if (hist[i] == m_level) all_diff = 1'b0;
      m_long    = (EXP_LONGS != 0) && m_level && !all_diff && (t - press_t == L - 1);
      m_press   = all_diff && !m_level;
      m_release = all_diff && m_level;
      if (all_diff) begin
        if (!m_level) press_t = t;
        m_level = !m_level;
      end
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic cmp_model();
    check("level", lvl, m_level);       check("press", prs, m_press);
    check("release", rel, m_release);   check("long", lng, m_long);
    check("level_al", lvl_n, m_level);  check("press_al", prs_n, m_press);
    check("release_al", rel_n, m_release); check("long_al", lng_n, m_long);
  endtask

  task automatic clear_counts();
    n_press = 0; n_release = 0; n_long = 0; last_press = -1; last_long = -1;
  endtask

  // k-th step of a sequence: pin value applied, one edge, outputs compared.
  task automatic step(input logic b, input int k);
    btn_in = b;
    @(posedge clk); #1;
    cyc++;
    cmp_model();
    if (prs) begin n_press++; last_press = k; end
    if (rel) n_release++;
    if (lng) begin n_long++; last_long = k; end
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_level", lvl, 1'b0); check("rst_press", prs, 1'b0);
    check("rst_release", rel, 1'b0); check("rst_long", lng, 1'b0);
    cmp_model();
    @(posedge clk); #1 reset = 1'b0;
  endtask

  typedef struct packed { logic rst; logic btn; logic lvl; logic prs; logic rel; } vec_t;
  vec_t tbl [16];

  initial begin
    logic b;
    int   len;
    // fields: rst btn | level press release
    tbl[0]  = 5'b11_000; tbl[1]  = 5'b01_000; tbl[2]  = 5'b01_000; tbl[3]  = 5'b01_000;
    tbl[4]  = 5'b01_000; tbl[5]  = 5'b01_000; tbl[6]  = 5'b01_110; tbl[7]  = 5'b01_100;
    tbl[8]  = 5'b01_100; tbl[9]  = 5'b00_100; tbl[10] = 5'b00_100; tbl[11] = 5'b00_100;
    tbl[12] = 5'b00_100; tbl[13] = 5'b00_100; tbl[14] = 5'b00_001; tbl[15] = 5'b00_000;

    #1;
    for (int i = 0; i < 16; i++) begin
      reset  = tbl[i].rst;
      btn_in = tbl[i].btn;
      @(posedge clk); #1;
      cyc++;
      check("tbl_level", lvl, tbl[i].lvl);
      check("tbl_press", prs, tbl[i].prs);
      check("tbl_release", rel, tbl[i].rel);
      check("tbl_long", lng, 1'b0);
      cmp_model();
    end

    // Glitch shorter than the debounce window
    clear_counts();
    for (int k = 1; k <= 3; k++) step(1'b1, k);
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, k);
      check("glitch_level", lvl, 1'b0);
    end
    check_int("glitch_presses", n_press, 0);
    check_int("glitch_releases", n_release, 0);

    // Bounce, then a steady press
    clear_counts();
    for (int k = 1; k <= 8; k++) step(((k - 1) / 2) % 2 == 0, k);
    for (int k = 1; k <= 12; k++) step(1'b1, k);
    check_int("bounce_presses", n_press, 1);
    check_int("bounce_press_cycle", last_press, 6);
    check("bounce_level", lvl, 1'b1);

    // Short dip while pressed, then a real release
    clear_counts();
    for (int k = 1; k <= 3; k++) step(1'b0, k);
    for (int k = 1; k <= 10; k++) step(1'b1, k);
    check_int("dip_releases", n_release, 0);
    for (int k = 1; k <= 10; k++) step(1'b0, k);
    check_int("release_count", n_release, 1);
    check("release_level", lvl, 1'b0);

    // Long hold, then a short press
    clear_counts();
    for (int k = 1; k <= 45; k++) step(1'b1, k);
    for (int k = 1; k <= 10; k++) step(1'b0, k);
    check_int("long_count", n_long, EXP_LONGS);
    if (EXP_LONGS != 0) check_int("long_delay", last_long - last_press, L - 1);
    clear_counts();
    for (int k = 1; k <= 10; k++) step(1'b1, k);
    for (int k = 1; k <= 10; k++) step(1'b0, k);
    check_int("short_press_count", n_press, 1);
    check_int("short_long_count", n_long, 0);

    // Reset while in RELEASE_WAIT with two differing samples counted
    clear_counts();
    for (int k = 1; k <= 8; k++) step(1'b1, k);
    for (int k = 1; k <= 4; k++) step(1'b0, k);
    check("rw_level_before", lvl, 1'b1);
    do_reset();
    for (int k = 1; k <= 15; k++) step(1'b0, k);
    check_int("rw_releases", n_release, 0);
    check("rw_level_after", lvl, 1'b0);

    // Random runs against the reference model
    for (int r = 0; r < 80; r++) begin
      b   = 1'($urandom_range(0, 1));
      len = ($urandom % 4 == 0) ? int'($urandom_range(15, 30)) : int'($urandom_range(1, 6));
      for (int k = 1; k <= len; k++) step(b, k);
      if ($urandom % 20 == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
